// File: rtl/tracer_multi_roi_io_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tracer_multi_roi_io_ctrl : multi-ROI tracer BRAM load/store FSM     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tracer_multi_roi_io_ctrl #(
  parameter int          NUM_ROI       = 4,
  parameter int          ROW_W         = 8,
  parameter int          COL_W         = 9,
  parameter int          CONTOUR_WORDS = 2,
  parameter int          TRACE_W       = 16,
  parameter int          RD_LAT        = 2,
  parameter int          TRACE_LAT     = 1,
  parameter int          MAX_FRAMES    = 256,
  parameter logic [31:0] CENTER_BASE   = 32'h0000_0000,
  parameter logic [31:0] CONTOUR_BASE  = 32'h0000_0100,
  parameter logic [31:0] TRACE_BASE    = 32'h0000_1000
) (
  input  logic                                             s_axi_aclk,
  input  logic                                             s_axi_areset,
  input  logic                                             load_start,
  input  logic                                             store_start,
  output logic                                             busy,
  output logic                                             load_done,
  output logic                                             store_end,
  output logic [((NUM_ROI > 1) ? $clog2(NUM_ROI) : 1)-1:0] roi_idx,
  output logic                                             load_center,
  output logic [ROW_W-1:0]                                 center_row,
  output logic [COL_W-1:0]                                 center_col,
  output logic                                             contour_rden,
  output logic                                             load_contour,
  output logic                                             contour_data,
  output logic                                             store_trace,
  input  logic [TRACE_W-1:0]                               acc_trace,
  output logic                                             tracer_buf_en,
  output logic [3:0]                                       tracer_buf_we,
  output logic [31:0]                                      tracer_buf_addr,
  output logic [31:0]                                      tracer_buf_din,
  input  logic [31:0]                                      tracer_buf_dout
);

  localparam int c_roi_w   = (NUM_ROI > 1) ? $clog2(NUM_ROI) : 1;
  localparam int c_word_w  = (CONTOUR_WORDS > 1) ? $clog2(CONTOUR_WORDS) : 1;
  localparam int c_frm_w   = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam int c_lat_max = (RD_LAT > TRACE_LAT) ? RD_LAT : TRACE_LAT;
  localparam int c_cnt_w   = $clog2(c_lat_max + 1);

  typedef enum logic [3:0] {
    IDLE, C_RD, C_WAIT, C_OUT, W_RD, W_WAIT, W_SHIFT, L_DONE,
    S_REQ, S_WAIT, S_WR, S_DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_roi_w-1:0]  w_roi_nxt;
  logic [c_word_w-1:0] r_word, w_word_nxt;
  logic [c_frm_w-1:0]  r_frame, w_frame_nxt;
  logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
  logic [4:0]          r_bit, w_bit_nxt;
  logic [31:0]         r_shift, w_shift_nxt;
  logic                r_load_pend, w_load_pend_nxt;
  logic                r_store_pend, w_store_pend_nxt;
  logic                w_center_upd, w_in_load, w_in_store;
  logic                w_last_roi, w_last_word;
  logic                w_en, w_contour_data;
  logic [3:0]          w_we;
  logic [31:0]         w_addr, w_din, w_roi32, w_word32, w_frame32;

  always_comb begin
    w_state_nxt      = r_state;
    w_roi_nxt        = roi_idx;
    w_word_nxt       = r_word;
    w_frame_nxt      = r_frame;
    w_cnt_nxt        = r_cnt;
    w_bit_nxt        = r_bit;
    w_shift_nxt      = r_shift;
    w_load_pend_nxt  = r_load_pend;
    w_store_pend_nxt = r_store_pend;
    w_center_upd     = 1'b0;
    w_last_roi       = (roi_idx == c_roi_w'(NUM_ROI - 1));
    w_last_word      = (r_word == c_word_w'(CONTOUR_WORDS - 1));
    w_in_load        = r_state inside {C_RD, C_WAIT, C_OUT, W_RD, W_WAIT, W_SHIFT, L_DONE};
    w_in_store       = r_state inside {S_REQ, S_WAIT, S_WR, S_DONE};

    // Cross requests queue up one deep; repeats of the running request drop.
    if (w_in_load && store_start) w_store_pend_nxt = 1'b1;
    if (w_in_store && load_start) w_load_pend_nxt = 1'b1;

    case (r_state)
      IDLE: begin
        if (load_start) begin
          w_state_nxt = C_RD;
          w_roi_nxt   = '0;
          if (store_start) w_store_pend_nxt = 1'b1;
        end else if (store_start) begin
          w_state_nxt = S_REQ;
          w_roi_nxt   = '0;
        end
      end
      C_RD: begin
        w_state_nxt = C_WAIT;
        w_cnt_nxt   = '0;
      end
      C_WAIT: begin
        if (r_cnt == c_cnt_w'(RD_LAT - 1)) begin
          w_state_nxt  = C_OUT;
          w_center_upd = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      C_OUT: begin
        w_state_nxt = W_RD;
        w_word_nxt  = '0;
      end
      W_RD: begin
        w_state_nxt = W_WAIT;
        w_cnt_nxt   = '0;
      end
      W_WAIT: begin
        if (r_cnt == c_cnt_w'(RD_LAT - 1)) begin
          w_state_nxt = W_SHIFT;
          w_shift_nxt = tracer_buf_dout;
          w_bit_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      W_SHIFT: begin
        w_shift_nxt = r_shift >> 1;
        if (r_bit == 5'd31) begin
          if (!w_last_word) begin
            w_state_nxt = W_RD;
            w_word_nxt  = r_word + c_word_w'(1);
          end else if (w_last_roi) begin
            w_state_nxt = L_DONE;
          end else begin
            w_state_nxt = C_RD;
            w_roi_nxt   = roi_idx + c_roi_w'(1);
          end
        end else begin
          w_bit_nxt = r_bit + 5'd1;
        end
      end
      L_DONE: begin
        if (r_store_pend || store_start) begin
          w_state_nxt      = S_REQ;
          w_roi_nxt        = '0;
          w_store_pend_nxt = 1'b0;
        end else begin
          w_state_nxt = IDLE;
          w_roi_nxt   = '0;
        end
      end
      S_REQ: begin
        if (TRACE_LAT == 0) begin
          w_state_nxt = S_WR;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (r_cnt == c_cnt_w'(TRACE_LAT - 1)) w_state_nxt = S_WR;
        else w_cnt_nxt = r_cnt + c_cnt_w'(1);
      end
      S_WR: begin
        if (w_last_roi) begin
          w_state_nxt = S_DONE;
          w_frame_nxt = (r_frame == c_frm_w'(MAX_FRAMES - 1)) ? '0 : r_frame + c_frm_w'(1);
        end else begin
          w_state_nxt = S_REQ;
          w_roi_nxt   = roi_idx + c_roi_w'(1);
        end
      end
      S_DONE: begin
        if (r_load_pend || load_start) begin
          w_state_nxt     = C_RD;
          w_roi_nxt       = '0;
          w_load_pend_nxt = 1'b0;
        end else begin
          w_state_nxt = IDLE;
          w_roi_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Outputs are precomputed from the state being entered so they register cleanly.
    w_roi32   = 32'(w_roi_nxt);
    w_word32  = 32'(w_word_nxt);
    w_frame32 = 32'(r_frame);
    w_en      = 1'b0;
    w_we      = 4'h0;
    w_addr    = 32'h0;
    w_din     = 32'h0;
    case (w_state_nxt)
      C_RD: begin
        w_en   = 1'b1;
        w_addr = CENTER_BASE + (w_roi32 << 2);
      end
      W_RD: begin
        w_en   = 1'b1;
        w_addr = CONTOUR_BASE + ((w_roi32 * 32'(CONTOUR_WORDS) + w_word32) << 2);
      end
      S_WR: begin
        w_en   = 1'b1;
        w_we   = 4'hF;
        w_addr = TRACE_BASE + ((w_frame32 * 32'(NUM_ROI) + w_roi32) << 2);
        w_din  = 32'(acc_trace);
      end
      default: ;
    endcase

    w_contour_data = 1'b0;
    if (w_state_nxt == W_SHIFT)
      w_contour_data = (r_state == W_SHIFT) ? r_shift[1] : tracer_buf_dout[0];
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state         <= IDLE;
      r_word          <= '0;
      r_frame         <= '0;
      r_cnt           <= '0;
      r_bit           <= '0;
      r_shift         <= '0;
      r_load_pend     <= 1'b0;
      r_store_pend    <= 1'b0;
      busy            <= 1'b0;
      load_done       <= 1'b0;
      store_end       <= 1'b0;
      roi_idx         <= '0;
      load_center     <= 1'b0;
      center_row      <= '0;
      center_col      <= '0;
      contour_rden    <= 1'b0;
      load_contour    <= 1'b0;
      contour_data    <= 1'b0;
      store_trace     <= 1'b0;
      tracer_buf_en   <= 1'b0;
      tracer_buf_we   <= 4'h0;
      tracer_buf_addr <= 32'h0;
      tracer_buf_din  <= 32'h0;
    end else begin
      r_state         <= w_state_nxt;
      r_word          <= w_word_nxt;
      r_frame         <= w_frame_nxt;
      r_cnt           <= w_cnt_nxt;
      r_bit           <= w_bit_nxt;
      r_shift         <= w_shift_nxt;
      r_load_pend     <= w_load_pend_nxt;
      r_store_pend    <= w_store_pend_nxt;
      busy            <= (w_state_nxt != IDLE);
      load_done       <= (w_state_nxt == L_DONE);
      store_end       <= (w_state_nxt == S_DONE);
      roi_idx         <= w_roi_nxt;
      load_center     <= (w_state_nxt == C_OUT);
      contour_rden    <= (w_state_nxt inside {W_RD, W_WAIT, W_SHIFT});
      load_contour    <= (w_state_nxt == W_SHIFT);
      contour_data    <= w_contour_data;
      store_trace     <= (w_state_nxt == S_REQ);
      tracer_buf_en   <= w_en;
      tracer_buf_we   <= w_we;
      tracer_buf_addr <= w_addr;
      tracer_buf_din  <= w_din;
      if (w_center_upd) begin
        center_row <= tracer_buf_dout[16 +: ROW_W];
        center_col <= tracer_buf_dout[0 +: COL_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tracer_multi_roi_io_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_tracer_multi_roi_io_ctrl : directed bench for the ROI controller |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_tracer_multi_roi_io_ctrl;

  localparam int SEL_EN = 0, SEL_CENTER = 1, SEL_CONTOUR = 2, SEL_LDONE = 3;
  localparam int SEL_SEND = 4, SEL_SEND2 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, load_start = 1'b0, store_start = 1'b0, store_start2 = 1'b0;
  logic        busy, load_done, store_end, load_center, contour_rden, load_contour;
  logic        contour_data, store_trace, en;
  logic [1:0]  roi_idx;
  logic [7:0]  center_row;
  logic [8:0]  center_col;
  logic [3:0]  we;
  logic [31:0] addr, din;
  logic [15:0] acc_trace = 16'h0, acc_trace2 = 16'h0;
  logic [31:0] dout = 32'h0, rd_pipe = 32'h0;

  logic        busy2, load_done2, store_end2, load_center2, contour_rden2, load_contour2;
  logic        contour_data2, store_trace2, en2;
  logic [1:0]  roi_idx2;
  logic [7:0]  center_row2;
  logic [8:0]  center_col2;
  logic [3:0]  we2;
  logic [31:0] addr2, din2;

  tracer_multi_roi_io_ctrl dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .load_start(load_start), .store_start(store_start),
    .busy(busy), .load_done(load_done), .store_end(store_end), .roi_idx(roi_idx),
    .load_center(load_center), .center_row(center_row), .center_col(center_col),
    .contour_rden(contour_rden), .load_contour(load_contour), .contour_data(contour_data),
    .store_trace(store_trace), .acc_trace(acc_trace), .tracer_buf_en(en),
    .tracer_buf_we(we), .tracer_buf_addr(addr), .tracer_buf_din(din), .tracer_buf_dout(dout)
  );

  tracer_multi_roi_io_ctrl #(.MAX_FRAMES(2)) dut2 (
    .s_axi_aclk(clk), .s_axi_areset(rst), .load_start(1'b0), .store_start(store_start2),
    .busy(busy2), .load_done(load_done2), .store_end(store_end2), .roi_idx(roi_idx2),
    .load_center(load_center2), .center_row(center_row2), .center_col(center_col2),
    .contour_rden(contour_rden2), .load_contour(load_contour2), .contour_data(contour_data2),
    .store_trace(store_trace2), .acc_trace(acc_trace2), .tracer_buf_en(en2),
    .tracer_buf_we(we2), .tracer_buf_addr(addr2), .tracer_buf_din(din2), .tracer_buf_dout(32'h0)
  );

  // BRAM with two cycles of read latency; junk appears whenever no read was issued.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    rd_pipe <= (en && we == 4'h0) ? mem[addr[12:2]] : 32'hBAD0_BAD0;
    dout    <= rd_pipe;
  end

  // Trace source: valid exactly one cycle after store_trace, junk otherwise.
  always @(posedge clk) begin
    acc_trace  <= store_trace  ? (16'h1234 + 16'(roi_idx))  : 16'hDEAD;
    acc_trace2 <= store_trace2 ? (16'h5000 + 16'(roi_idx2)) : 16'hDEAD;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  we;
    int          cyc;
  } wr_t;

  wr_t wq[$], wq2[$];
  wr_t wtmp, wtmp2;
  int  cyc = 0, cnt_ld = 0, cnt_se = 0, cnt_se2 = 0, ld_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en && we != 4'h0) begin
      wtmp.addr = addr; wtmp.din = din; wtmp.we = we; wtmp.cyc = cyc;
      wq.push_back(wtmp);
    end
    if (en2 && we2 != 4'h0) begin
      wtmp2.addr = addr2; wtmp2.din = din2; wtmp2.we = we2; wtmp2.cyc = cyc;
      wq2.push_back(wtmp2);
    end
    if (load_done) begin cnt_ld++; ld_cyc = cyc; end
    if (store_end) cnt_se++;
    if (store_end2) cnt_se2++;
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic logic sel(input int which);
    case (which)
      SEL_EN:      return en;
      SEL_CENTER:  return load_center;
      SEL_CONTOUR: return load_contour;
      SEL_LDONE:   return load_done;
      SEL_SEND:    return store_end;
      SEL_SEND2:   return store_end2;
      default:     return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int which, input string name, input int limit);
    int n = 0;
    while (!sel(which) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!sel(which)) begin
      n_total++;
      $display("FAIL timeout %s: no pulse within %0d cycles, required one", name, limit);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctrl"}, {17'h0, busy, load_done, store_end, load_center, contour_rden,
          load_contour, contour_data, store_trace, en, we, roi_idx}, 32'h0);
    check({tag, " addr"}, addr, 32'h0);
    check({tag, " din"}, din, 32'h0);
    check({tag, " centre"}, {15'h0, center_row, center_col}, 32'h0);
  endtask

  typedef struct {
    logic [31:0] center;
    logic [31:0] cw [2];
    logic [7:0]  exp_row;
    logic [8:0]  exp_col;
  } roi_vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
  } st_vec_t;

  roi_vec_t lv [4];
  st_vec_t  sv [8];
  logic [31:0] st2_base [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int wb, lb, sb;
    logic [31:0] word;
    logic        vld;
    int          t0;

    lv[0] = '{32'h0012_0034, '{32'h8000_0001, 32'h1234_5678}, 8'h12, 9'h034};
    lv[1] = '{32'h00AB_01FF, '{32'hDEAD_BEEF, 32'h0F0F_0F0F}, 8'hAB, 9'h1FF};
    lv[2] = '{32'hFFFF_FE00, '{32'hFFFF_FFFF, 32'h0000_0000}, 8'hFF, 9'h000};
    lv[3] = '{32'h5A3C_C3A5, '{32'hA5A5_5A5A, 32'h7FFF_FFFE}, 8'h3C, 9'h1A5};
    sv[0] = '{32'h1000, 32'h1234}; sv[1] = '{32'h1004, 32'h1235};
    sv[2] = '{32'h1008, 32'h1236}; sv[3] = '{32'h100C, 32'h1237};
    sv[4] = '{32'h1010, 32'h1234}; sv[5] = '{32'h1014, 32'h1235};
    sv[6] = '{32'h1018, 32'h1236}; sv[7] = '{32'h101C, 32'h1237};
    st2_base[0] = 32'h1000; st2_base[1] = 32'h1010; st2_base[2] = 32'h1000;

    for (int r = 0; r < 4; r++) begin
      mem[r] = lv[r].center;
      mem[32'h40 + 2 * r]     = lv[r].cw[0];
      mem[32'h40 + 2 * r + 1] = lv[r].cw[1];
    end

    // Reset held for three cycles
    rst = 1'b1;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);

    // Full load, checked against the ROI table
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      wait_for(SEL_EN, $sformatf("r%0d centre en", r), 10);
      check($sformatf("r%0d centre addr", r), en ? addr : 32'hFFFF_FFFF, 32'(4 * r));
      t0 = cyc;
      @(negedge clk);
      wait_for(SEL_CENTER, $sformatf("r%0d load_center", r), 10);
      check($sformatf("r%0d centre latency", r), 32'(cyc - t0), 32'd3);
      check($sformatf("r%0d row", r), 32'(center_row), 32'(lv[r].exp_row));
      check($sformatf("r%0d col", r), 32'(center_col), 32'(lv[r].exp_col));
      check($sformatf("r%0d roi_idx", r), 32'(roi_idx), 32'(r));
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
        check($sformatf("r%0d w%0d read addr", r, w), en ? addr : 32'hFFFF_FFFF,
              32'h100 + 32'(8 * r + 4 * w));
        t0 = cyc;
        wait_for(SEL_CONTOUR, $sformatf("r%0d w%0d contour", r, w), 10);
        check($sformatf("r%0d w%0d bit latency", r, w), 32'(cyc - t0), 32'd3);
        word = 32'h0;
        vld  = 1'b1;
        for (int k = 0; k < 32; k++) begin
          if (!(load_contour && contour_rden)) vld = 1'b0;
          word[k] = contour_data;
          @(negedge clk);
        end
        check($sformatf("r%0d w%0d bits", r, w), word, lv[r].cw[w]);
        check($sformatf("r%0d w%0d valid run", r, w), 32'(vld), 32'd1);
      end
      check($sformatf("r%0d rden falls", r), 32'(contour_rden), 32'd0);
    end
    check("load_done after ROI3", 32'(load_done), 32'd1);
    @(negedge clk);
    check("load idle after", {30'h0, load_done, busy}, 32'h0);
    check("load_done count", 32'(cnt_ld), 32'd1);

    // Two stores, checked against the write table
    wb = wq.size();
    sb = cnt_se;
    for (int s = 0; s < 2; s++) begin
      store_start = 1'b1;
      @(negedge clk);
      store_start = 1'b0;
      wait_for(SEL_SEND, $sformatf("store %0d end", s), 40);
      tick(2);
    end
    for (int i = 0; i < 8; i++) begin
      wtmp = (wb + i < wq.size()) ? wq[wb + i] : '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h0, 0};
      check($sformatf("st%0d addr", i), wtmp.addr, sv[i].addr);
      check($sformatf("st%0d din", i), wtmp.din, sv[i].din);
      check($sformatf("st%0d we", i), 32'(wtmp.we), 32'hF);
    end
    check("store write count", 32'(wq.size() - wb), 32'd8);
    check("store_end count", 32'(cnt_se - sb), 32'd2);

    // Simultaneous starts, plus a repeated load request mid-load
    wb = wq.size(); sb = cnt_se; lb = cnt_ld;
    load_start = 1'b1; store_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0; store_start = 1'b0;
    tick(20);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    wait_for(SEL_SEND, "pending store end", 600);
    tick(10);
    check("both: load_done count", 32'(cnt_ld - lb), 32'd1);
    check("both: store_end count", 32'(cnt_se - sb), 32'd1);
    check("both: write count", 32'(wq.size() - wb), 32'd4);
    wtmp = (wb < wq.size()) ? wq[wb] : '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h0, 0};
    check("both: frame2 addr", wtmp.addr, 32'h1020);
    check("both: store after load", 32'(wtmp.cyc > ld_cyc), 32'd1);
    check("both: idle after", 32'(busy), 32'd0);

    // Reset during contour shifting with a store pending
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    tick(3);
    store_start = 1'b1;
    @(negedge clk);
    store_start = 1'b0;
    wait_for(SEL_CONTOUR, "shift before reset", 20);
    tick(3);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("mid-shift reset");
    rst = 1'b0;
    tick(5);
    wb = wq.size();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    wait_for(SEL_LDONE, "post-reset load_done", 400);
    tick(20);
    check("pend cleared: no store", 32'(wq.size() - wb), 32'd0);
    check("pend cleared: idle", 32'(busy), 32'd0);
    store_start = 1'b1;
    @(negedge clk);
    store_start = 1'b0;
    wait_for(SEL_SEND, "post-reset store", 40);
    tick(2);
    wtmp = (wb < wq.size()) ? wq[wb] : '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h0, 0};
    check("frame reset addr", wtmp.addr, 32'h1000);

    // Frame index wrap with two frame slots
    for (int s = 0; s < 3; s++) begin
      store_start2 = 1'b1;
      @(negedge clk);
      store_start2 = 1'b0;
      wait_for(SEL_SEND2, $sformatf("wrap store %0d", s), 40);
      tick(2);
    end
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k += 3) begin
        wtmp2 = (4 * s + k < wq2.size()) ? wq2[4 * s + k]
                                          : '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h0, 0};
        check($sformatf("wrap s%0d r%0d addr", s, k), wtmp2.addr, st2_base[s] + 32'(4 * k));
        check($sformatf("wrap s%0d r%0d din", s, k), wtmp2.din, 32'h5000 + 32'(k));
      end
    end
    check("wrap store_end count", 32'(cnt_se2), 32'd3);
    check("wrap no load activity", {13'h0, busy2, load_done2, load_center2, contour_rden2,
          load_contour2, contour_data2, center_row2, center_col2}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tracer_multi_roi_io_ctrl.md
Name: tracer_multi_roi_io_ctrl

Overview:
Single-FSM tracer-buffer controller that serves NUM_ROI regions of interest per frame. On load it reads each ROI's centre word and contour bitmap words from the tracer BRAM, presenting centre row/col and a bit-serial contour stream to the tracer core. On store it requests one accumulated trace per ROI and writes it to a frame-indexed trace area. The block is the sole owner of the tracer BRAM port, so accesses are mutually exclusive by construction.

Parameters:
NUM_ROI, 4, ROIs per frame (>=1)
ROW_W, 8, centre row width (<=16)
COL_W, 9, centre column width (<=16)
CONTOUR_WORDS, 2, 32-bit contour words per ROI (>=1)
TRACE_W, 16, trace width (<=32)
RD_LAT, 2, BRAM read latency in cycles (>=1)
TRACE_LAT, 1, cycles from store_trace to a valid acc_trace (>=0)
MAX_FRAMES, 256, trace frame slots; the frame index wraps here
CENTER_BASE, 32'h0000, centre table byte address
CONTOUR_BASE, 32'h0100, contour table byte address
TRACE_BASE, 32'h1000, trace area byte address

Ports:
s_axi_aclk  in  1  clock
s_axi_areset  in  1  synchronous, active-high reset
load_start  in  1  one-cycle request to start a load
store_start  in  1  one-cycle request to start a store
busy  out  1  high whenever the FSM is not in IDLE
load_done  out  1  one-cycle pulse when a load completes
store_end  out  1  one-cycle pulse when a store completes
roi_idx  out  $clog2(NUM_ROI) (min 1)  ROI currently being served
load_center  out  1  centre-valid pulse
center_row  out  ROW_W  centre row
center_col  out  COL_W  centre column
contour_rden  out  1  level, high for the duration of an ROI's contour phase
load_contour  out  1  contour bit valid
contour_data  out  1  contour bit
store_trace  out  1  trace request pulse
acc_trace  in  TRACE_W  trace value
tracer_buf_en  out  1  BRAM enable
tracer_buf_we  out  4  byte write enables
tracer_buf_addr  out  32  BRAM byte address
tracer_buf_din  out  32  BRAM write data
tracer_buf_dout  in  32  BRAM read data

Behaviour:
- Reset values: every output is 0; FSM goes to IDLE; frame_idx=0; pending flags cleared. Reset mid-operation aborts immediately and takes effect on the next edge.
- All outputs are registered. When tracer_buf_en=0, we, addr and din are 0.
- States: IDLE, C_RD, C_WAIT, C_OUT, W_RD, W_WAIT, W_SHIFT, L_DONE, S_REQ, S_WAIT, S_WR, S_DONE.
- IDLE: load_start has priority. If load_start and store_start arrive in the same cycle, go to C_RD with roi=0 and set store_pend. Otherwise load_start goes to C_RD and store_start goes to S_REQ.
- Start requests that arrive while busy:
  - load_start during a store sets load_pend.
  - store_start during a load sets store_pend.
  - A repeat of the request already in progress is ignored.
  - Pending flags are single-depth and are serviced from L_DONE or S_DONE instead of returning to IDLE.
- Centre read:
  - C_RD: en=1, we=0, addr=CENTER_BASE+4*roi.
  - Data is sampled after RD_LAT cycles.
  - C_OUT: load_center=1 for one cycle with center_row=dout[16+ROW_W-1:16] and center_col=dout[COL_W-1:0]. Row/col are held until the next update.
- Contour read:
  - contour_rden rises in the first W_RD and falls after the ROI's last bit.
  - For each word w: W_RD issues addr=CONTOUR_BASE+4*(roi*CONTOUR_WORDS+w). After RD_LAT cycles the word is captured.
  - W_SHIFT then lasts 32 cycles with load_contour=1 and contour_data=word[k], k=0..31, LSB first.
  - The next W_RD follows the cycle after the last bit.
  - After the last word: roi++ and return to C_RD. After the last ROI go to L_DONE, which pulses load_done.
- Store:
  - S_REQ: store_trace=1 for one cycle.
  - S_WAIT: TRACE_LAT cycles, then acc_trace is sampled (TRACE_LAT=0 samples in the S_REQ cycle).
  - S_WR: en=1, we=4'b1111, addr=TRACE_BASE+4*(frame_idx*NUM_ROI+roi), din=zero-extended trace.
  - Next ROI starts at S_REQ. After the last ROI go to S_DONE: store_end pulses and frame_idx increments, wrapping from MAX_FRAMES-1 to 0.
- Address arithmetic is 32-bit unsigned; overflow is not checked.

Test Plan:
- Reset: hold s_axi_areset 3 cycles while mid-idle -> all outputs 0; busy=0.
- Load, defaults: centre 0x0012_0034 at 0x0, contour 0x8000_0001 at 0x100 ->
  - load_center is seen 3 cycles after the en cycle, with row=0x12 and col=0x034.
  - Contour bits are 1, 0 (x30), 1.
  - Reads go to 0x0, 0x100, 0x104, then 0x4, and so on.
  - load_done pulses once after the ROI3 bits.
- Store twice with acc_trace=0x1234+roi ->
  - First store writes 0x1234..0x1237 to 0x1000..0x100C with we=4'hF.
  - Second store writes to 0x1010..0x101C.
  - store_end pulses once per store.
- store_start and load_start in the same IDLE cycle -> the full load runs first, then exactly one store; a second load_start during the load is ignored.
- Reset asserted mid-W_SHIFT -> next cycle all outputs 0, FSM in IDLE, pending flags cleared, frame_idx=0.
- MAX_FRAMES=2, three stores -> the third store writes again at 0x1000.
